// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the single-port data RAM between the core load/store
// path (m0) and an external debug/DMA master (m1). Grants are combinational,
// read data returns one cycle after the grant and is steered to its owner.
// m1 is protected against starvation and may lock the RAM for atomic sequences.
module dbus_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic          clk,
  input  logic          rstn,

  // core MEM-stage port
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_wmask,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          stall_o,

  // external master port
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wmask,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  // RAM side
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic [3:0]    ram_wmask,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {
    ARB  = 1'b0,   // normal arbitration between m0 and m1
    LOCK = 1'b1    // m1 owns the RAM until it unlocks or drops its request
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_owner_q, rsp_owner_d;   // 0 = m0, 1 = m1
  logic       gnt0, gnt1;

  // Grant selection, next state and starvation counter update.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      ARB: begin
        if (m0_req && m1_req) begin
          // m0 normally wins; m1 is forced in once it has waited long enough
          if (starve_cnt_q == STARVE_LIM) gnt1 = 1'b1;
          else                            gnt0 = 1'b1;
        end else if (m0_req) begin
          gnt0 = 1'b1;
        end else if (m1_req) begin
          gnt1 = 1'b1;
        end
        if (gnt1 && m1_lock) state_d = LOCK;
      end
      LOCK: begin
        // m0 is shut out entirely while m1 holds the lock
        gnt1 = m1_req;
        if ((gnt1 && !m1_lock) || !m1_req) state_d = ARB;
      end
      default: state_d = ARB;
    endcase

    if (gnt1 || !m1_req) begin
      starve_cnt_d = 4'd0;
    end else if (gnt0 && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // no grant may escape while reset is held
    if (!rstn) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Read-response bookkeeping: a granted read returns data next cycle.
  always_comb begin
    rsp_valid_d = (gnt0 && !m0_we) || (gnt1 && !m1_we);
    rsp_owner_d = gnt1;
  end

  // State, starvation counter and response tracking registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values together.
    if (!rstn) begin
      state_q      <= ARB;
      starve_cnt_q <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  // RAM request mux: fields come from the granted master, zero when idle.
  always_comb begin
    ram_ce    = gnt0 | gnt1;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wmask = 4'b0000;
    if (gnt0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_wmask = m0_wmask;
    end else if (gnt1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_wmask = m1_wmask;
    end
  end

  // Requester-facing outputs: grants, stall and steered read data.
  always_comb begin
    m0_gnt    = gnt0;
    m1_gnt    = gnt1;
    stall_o   = rstn && m0_req && !gnt0;
    m0_rvalid = rstn && rsp_valid_q && !rsp_owner_q;
    m1_rvalid = rstn && rsp_valid_q &&  rsp_owner_q;
    m0_rdata  = m0_rvalid ? ram_rdata : '0;
    m1_rdata  = m1_rvalid ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed testbench for dbus_arbiter with a 1-cycle-latency RAM model.
module tb_dbus_arbiter;

  logic        clk;
  logic        rstn;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        stall_o;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_wmask;

  logic [31:0] mem [0:1023];
  logic        mem_init;

  int total;
  int passed;
  int fails;

  dbus_arbiter #(.STARVE_MAX(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wmask  (m0_wmask),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .stall_o   (stall_o),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wmask  (m1_wmask),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model: byte-masked writes, registered read data.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
      mem[64] <= 32'hDEADBEEF;   // 0x100
      mem[65] <= 32'h12345678;   // 0x104
      mem[4]  <= 32'hFFFFFF00;   // 0x010
      ram_rdata <= 32'h0;
    end else if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[11:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp1;
    logic prev1;
    total = 0; passed = 0; fails = 0;
    mem_init = 1'b1;
    rstn = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = '0; m0_wmask = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_lock = 1'b0;

    // reset held with m0 requesting: every output stays low
    cyc();
    mem_init = 1'b0;
    check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_ram_ce", 32'(ram_ce), 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    m0_req = 1'b0;
    rstn = 1'b1;
    cyc();

    // single m0 read of 0x100
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    settle();
    check("rd_m0_gnt", 32'(m0_gnt), 32'd1);
    check("rd_ram_ce", 32'(ram_ce), 32'd1);
    check("rd_ram_addr", ram_addr, 32'h100);
    check("rd_ram_we", 32'(ram_we), 32'd0);
    check("rd_stall", 32'(stall_o), 32'd0);
    cyc();
    m0_req = 1'b0;
    settle();
    check("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
    check("rd_idle_ram_ce", 32'(ram_ce), 32'd0);

    // starvation limit: both read continuously, m1 wins every 5th cycle
    cyc();
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h104; m1_lock = 1'b0;
    settle();
    for (int i = 0; i < 10; i++) begin
      exp1 = ((i % 5) == 4);
      check($sformatf("stv_m0_gnt[%0d]", i), 32'(m0_gnt), 32'(!exp1));
      check($sformatf("stv_m1_gnt[%0d]", i), 32'(m1_gnt), 32'(exp1));
      check($sformatf("stv_stall[%0d]", i), 32'(stall_o), 32'(exp1));
      check($sformatf("stv_addr[%0d]", i), ram_addr, exp1 ? 32'h104 : 32'h100);
      if (i > 0) begin
        prev1 = (((i - 1) % 5) == 4);
        check($sformatf("stv_m0_rvalid[%0d]", i), 32'(m0_rvalid), 32'(!prev1));
        check($sformatf("stv_m1_rvalid[%0d]", i), 32'(m1_rvalid), 32'(prev1));
        check($sformatf("stv_m0_rdata[%0d]", i), m0_rdata, prev1 ? 32'h0 : 32'hDEADBEEF);
        check($sformatf("stv_m1_rdata[%0d]", i), m1_rdata, prev1 ? 32'h12345678 : 32'h0);
      end
      cyc();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    settle();
    check("stv_last_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("stv_last_m1_rdata", m1_rdata, 32'h12345678);
    check("stv_last_m0_rvalid", 32'(m0_rvalid), 32'd0);

    // lock: m1 locked write 0x200 then unlocking write 0x204, m0 requesting
    cyc();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'hCAFEF00D;
    m1_wmask = 4'hF; m1_lock = 1'b1;
    settle();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("lk_pre_m0_gnt[%0d]", j), 32'(m0_gnt), 32'd1);
      check($sformatf("lk_pre_m1_gnt[%0d]", j), 32'(m1_gnt), 32'd0);
      cyc();
    end
    check("lk_w1_m1_gnt", 32'(m1_gnt), 32'd1);
    check("lk_w1_m0_gnt", 32'(m0_gnt), 32'd0);
    check("lk_w1_stall", 32'(stall_o), 32'd1);
    check("lk_w1_ram_we", 32'(ram_we), 32'd1);
    check("lk_w1_ram_addr", ram_addr, 32'h200);
    check("lk_w1_ram_wdata", ram_wdata, 32'hCAFEF00D);
    cyc();
    m1_addr = 32'h204; m1_wdata = 32'h0BADC0DE; m1_lock = 1'b0;
    settle();
    check("lk_w2_m1_gnt", 32'(m1_gnt), 32'd1);
    check("lk_w2_m0_gnt", 32'(m0_gnt), 32'd0);
    check("lk_w2_stall", 32'(stall_o), 32'd1);
    check("lk_w2_ram_addr", ram_addr, 32'h204);
    check("lk_w2_m1_rvalid", 32'(m1_rvalid), 32'd0);
    check("lk_w2_m0_rvalid", 32'(m0_rvalid), 32'd0);
    cyc();
    m1_req = 1'b0; m1_we = 1'b0; m1_wdata = '0; m1_wmask = '0;
    settle();
    check("lk_post_m0_gnt", 32'(m0_gnt), 32'd1);
    check("lk_post_stall", 32'(stall_o), 32'd0);
    check("lk_post_m1_gnt", 32'(m1_gnt), 32'd0);

    // lock released by m1 dropping its request
    cyc();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h104; m1_lock = 1'b1;
    settle();
    check("drop_m1_gnt", 32'(m1_gnt), 32'd1);
    check("drop_m0_rvalid", 32'(m0_rvalid), 32'd1);
    cyc();
    m1_req = 1'b0; m1_lock = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h100;
    settle();
    check("drop_lock_m0_gnt", 32'(m0_gnt), 32'd0);
    check("drop_lock_stall", 32'(stall_o), 32'd1);
    check("drop_lock_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("drop_lock_m1_rdata", m1_rdata, 32'h12345678);
    cyc();
    m1_req = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) begin
      exp1 = (k == 4);
      check($sformatf("drop_arb_m0_gnt[%0d]", k), 32'(m0_gnt), 32'(!exp1));
      check($sformatf("drop_arb_m1_gnt[%0d]", k), 32'(m1_gnt), 32'(exp1));
      cyc();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    settle();

    // reset asserted while an m0 read is in flight
    cyc();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    settle();
    check("rstrd_m0_gnt", 32'(m0_gnt), 32'd1);
    cyc();
    m0_req = 1'b0;
    rstn = 1'b0;
    settle();
    check("rstrd_m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("rstrd_m0_rdata", m0_rdata, 32'h0);
    cyc();
    rstn = 1'b1;
    settle();
    check("rstrd_post_m0_rvalid", 32'(m0_rvalid), 32'd0);
    check("rstrd_post_m1_rvalid", 32'(m1_rvalid), 32'd0);
    check("rstrd_post_ram_ce", 32'(ram_ce), 32'd0);
    check("rstrd_post_stall", 32'(stall_o), 32'd0);
    m0_req = 1'b1;
    settle();
    check("rstrd_first_m0_gnt", 32'(m0_gnt), 32'd1);
    check("rstrd_first_ram_addr", ram_addr, 32'h100);
    cyc();
    m0_req = 1'b0;
    settle();
    check("rstrd_first_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("rstrd_first_m0_rdata", m0_rdata, 32'hDEADBEEF);

    // masked write of 0xA5 to 0x10 followed by a read back
    cyc();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h000000A5; m0_wmask = 4'b0001;
    settle();
    check("wr_m0_gnt", 32'(m0_gnt), 32'd1);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_wmask", 32'(ram_wmask), 32'h1);
    check("wr_ram_wdata", ram_wdata, 32'h000000A5);
    cyc();
    m0_we = 1'b0; m0_wdata = '0; m0_wmask = '0;
    settle();
    check("wr_no_rvalid", 32'(m0_rvalid), 32'd0);
    check("rb_m0_gnt", 32'(m0_gnt), 32'd1);
    check("rb_ram_we", 32'(ram_we), 32'd0);
    cyc();
    m0_req = 1'b0;
    settle();
    check("rb_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("rb_m0_rdata", m0_rdata, 32'hFFFFFFA5);
    cyc();
    check("rb_after_rvalid", 32'(m0_rvalid), 32'd0);

    // m1 locked writes landed in RAM
    check("mem_0x200", mem[128], 32'hCAFEF00D);
    check("mem_0x204", mem[129], 32'h0BADC0DE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Arbitrates the single-port data RAM between two requesters: m0, the core MEM-stage load/store path feeding the load-data extraction logic, and m1, an external master (debug/DMA).
- Issues RAM strobes and routes 1-cycle-latency read data back to the owning requester.
- Stalls the core pipeline while m0 is refused.
- Provides starvation protection for m1 and a lock for atomic m1 sequences.

Parameters:
- STARVE_MAX, 4: max consecutive m0 grants while m1_req is pending before m1 is forced a grant (range 1..15).
- AW, 32: address width (matches MemAddrBus).
- DW, 32: data width (matches MemBus).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  synchronous active-low reset
- m0_req  in  1  core access request
- m0_we  in  1  core write enable (0=read)
- m0_addr  in  AW  core byte address
- m0_wdata  in  DW  core write data
- m0_wmask  in  4  core byte write mask
- m0_gnt  out  1  core request accepted this cycle
- m0_rvalid  out  1  core read data valid
- m0_rdata  out  DW  core read data (whole word; byte/half selection stays in MEM stage)
- stall_o  out  1  pipeline hold: m0_req & ~m0_gnt
- m1_req, m1_we, m1_addr, m1_wdata, m1_wmask  in  1/1/AW/DW/4  external master request fields
- m1_lock  in  1  keep ownership after this m1 access
- m1_gnt, m1_rvalid  out  1  external master grant / read valid
- m1_rdata  out  DW  external master read data
- ram_ce  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_wmask  out  4  RAM byte mask
- ram_rdata  in  DW  RAM read data, valid the cycle after a ce & ~we access

Behaviour:
- **States:** ARB (normal) and LOCK (m1 owns the RAM). The next-state register, starve_cnt, rsp_valid_q and rsp_owner_q update on posedge clk.

- **Grant in ARB:**
  - Only m0_req: grant m0.
  - Only m1_req: grant m1.
  - Both: grant m1 if starve_cnt==STARVE_MAX, else grant m0.
  - Grants are combinational from the current state and requests. At most one grant per cycle.

- **Grant in LOCK:** only m1 may be granted; m0 is refused (stall_o=1 whenever m0_req).

- **Transitions:**
  - ARB->LOCK when m1_gnt & m1_lock.
  - LOCK->ARB when (m1_gnt & ~m1_lock) or ~m1_req.
  - Otherwise hold.

- **starve_cnt:**
  - Increments (saturating at STARVE_MAX) on m0_gnt & m1_req.
  - Clears on m1_gnt or ~m1_req.
  - Holds otherwise.

- **RAM mux:**
  - ram_ce = m0_gnt | m1_gnt.
  - ram_we/addr/wdata/wmask come from the granted master.
  - All RAM outputs are zero when no grant.

- **Read response:**
  - rsp_valid_q <= granted & ~we; rsp_owner_q <= granted master.
  - Next cycle: mX_rvalid = rsp_valid_q & (owner==X); mX_rdata = ram_rdata when its rvalid is set, else 0.
  - Back-to-back accesses are fully pipelined: one access per cycle, no bubble on owner switch.

- **Writes:** complete in the grant cycle; no rvalid is produced.

- **Reset (rstn=0 at a clock edge):**
  - State=ARB, starve_cnt=0, rsp_valid_q=0.
  - While rstn=0 all outputs are forced 0: gnt, rvalid, rdata, ram_*, stall_o.
  - A read in flight when reset is asserted never returns rvalid.

- **Simultaneous events:**
  - m1 granted with m1_lock=1 while m0 is also requesting: m0 stalls from the next cycle until the lock is released.
  - A req dropped mid-stall is legal and needs no handshake.
  - Requests are level-sensitive; a requester must hold its fields stable until its gnt.

Test Plan:
- **Single reads:** m0 read addr 0x100 (RAM holds 0xDEADBEEF) with m1 idle -> m0_gnt same cycle, ram_ce=1, ram_addr=0x100, ram_we=0; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- **Starvation limit:** m0 and m1 both request reads continuously, STARVE_MAX=4 -> grant sequence m0,m0,m0,m0,m1,m0,... (period 5); stall_o=1 exactly in the m1-granted cycles; rdata goes to the correct owner each cycle.
- **Lock:** m1 writes 0x200 with m1_lock=1, then writes 0x204 with m1_lock=0, while m0 requests throughout -> both m1 writes granted on consecutive cycles, m0 stalled 2 cycles, m0 granted the cycle after the unlocking write.
- **Lock release by drop:** in LOCK, m1_req drops to 0 -> next cycle state ARB, pending m0 granted, starve_cnt=0.
- **Reset mid-read:** rstn=0 in the cycle after an m0 read grant -> m0_rvalid stays 0; after release, all outputs 0 and the first m0 request is granted immediately.
- **Write then read:** m0 write 0xA5 to addr 0x10 with wmask=4'b0001, then m0 read of 0x10 -> ram_wmask=0001 in the write cycle, no rvalid for the write, rvalid only for the read, one cycle after its grant.
